// File: rtl/burst_ram_pkg.sv
// Shared definitions for the burst RAM arbiter and its helpers.
//   state_t           : arbiter FSM states
//   REQ_A / REQ_B     : requester ids (A = instruction cache, B = data cache)
//   BURST_BEATS       : beats per burst (read and write)
//   BEAT_BITWIDTH     : width of one data beat
//   BEAT_CNT_BITWIDTH : width of the beat counter
//   LAST_BEAT         : beat counter value of the final beat
package burst_ram_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        WRITE_BEATS = 2'd1,
        READ_WAIT   = 2'd2
    } state_t;

    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    localparam int BURST_BEATS       = 4;
    localparam int BEAT_BITWIDTH     = 64;
    localparam int BEAT_CNT_BITWIDTH = $clog2(BURST_BEATS);

    localparam logic [BEAT_CNT_BITWIDTH-1:0] LAST_BEAT = BEAT_CNT_BITWIDTH'(BURST_BEATS - 1);

endpackage

// File: rtl/command_delay_counter.sv
// Minimum command interval timer. Loading sets the count to
// COMMAND_DELAY_INTERVAL; it then counts down by one per cycle and rests at 0.
// Ports:
//   clk  : clock
//   rst  : synchronous active-high reset (count -> 0)
//   load : reload the interval (a command is being issued this cycle)
//   zero : count is 0, a new command may be issued
module command_delay_counter #(
    parameter int COMMAND_DELAY_INTERVAL = 13
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic zero
);

    localparam int CNT_BITWIDTH = (COMMAND_DELAY_INTERVAL > 0) ? $clog2(COMMAND_DELAY_INTERVAL + 1) : 1;
    localparam logic [CNT_BITWIDTH-1:0] LOAD_VALUE = CNT_BITWIDTH'(COMMAND_DELAY_INTERVAL);

    logic [CNT_BITWIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VALUE;
        end else if (count != '0) begin
            count <= count - CNT_BITWIDTH'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one PSRAM burst RAM port between the instruction cache (A) and the
// data cache (B). Commands are serialized with round-robin on ties, spaced by
// the command delay counter, write beats are streamed from the owner, and
// read beats are routed back to the owner only.
// Ports:
//   clk, rst                          : clock, synchronous active-high reset
//   a_/b_cmd, a_/b_cmd_en             : command (0 read, 1 write) and request level
//   a_/b_addr, a_/b_wr_data           : burst address, write beats
//   a_/b_cmd_ack                      : one-cycle pulse when the command is issued
//   a_/b_rd_data, a_/b_rd_data_valid  : read beats forwarded to the owner
//   br_cmd, br_cmd_en, br_addr        : command to the burst RAM
//   br_wr_data, br_data_mask          : write beats, mask (always 0)
//   br_rd_data, br_rd_data_valid      : read beats from the burst RAM
module burst_ram_arbiter
    import burst_ram_pkg::*;
#(
    parameter int RAM_DEPTH_BITWIDTH     = 21,
    parameter int COMMAND_DELAY_INTERVAL = 13
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          a_cmd,
    input  logic                          a_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0] a_addr,
    input  logic [BEAT_BITWIDTH-1:0]      a_wr_data,
    output logic                          a_cmd_ack,
    output logic [BEAT_BITWIDTH-1:0]      a_rd_data,
    output logic                          a_rd_data_valid,
    input  logic                          b_cmd,
    input  logic                          b_cmd_en,
    input  logic [RAM_DEPTH_BITWIDTH-1:0] b_addr,
    input  logic [BEAT_BITWIDTH-1:0]      b_wr_data,
    output logic                          b_cmd_ack,
    output logic [BEAT_BITWIDTH-1:0]      b_rd_data,
    output logic                          b_rd_data_valid,
    output logic                          br_cmd,
    output logic                          br_cmd_en,
    output logic [RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [BEAT_BITWIDTH-1:0]      br_wr_data,
    output logic [7:0]                    br_data_mask,
    input  logic [BEAT_BITWIDTH-1:0]      br_rd_data,
    input  logic                          br_rd_data_valid
);

    state_t                       state;
    state_t                       state_next;
    logic                         owner;
    logic                         owner_next;
    logic                         last_grant;
    logic                         last_grant_next;
    logic [BEAT_CNT_BITWIDTH-1:0] beat_cnt;
    logic [BEAT_CNT_BITWIDTH-1:0] beat_cnt_next;
    logic                         issue;
    logic                         winner;
    logic                         cmd_ready;

    logic                          src;
    logic                          src_cmd;
    logic [RAM_DEPTH_BITWIDTH-1:0] src_addr;
    logic [BEAT_BITWIDTH-1:0]      src_wr_data;

    command_delay_counter #(
        .COMMAND_DELAY_INTERVAL(COMMAND_DELAY_INTERVAL)
    ) u_delay (
        .clk (clk),
        .rst (rst),
        .load(issue),
        .zero(cmd_ready)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            owner      <= REQ_A;
            last_grant <= REQ_B;
            beat_cnt   <= '0;
        end else begin
            state      <= state_next;
            owner      <= owner_next;
            last_grant <= last_grant_next;
            beat_cnt   <= beat_cnt_next;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        beat_cnt_next   = beat_cnt;
        issue           = 1'b0;
        winner          = REQ_A;
        case (state)
            IDLE: begin
                if (cmd_ready && (a_cmd_en || b_cmd_en)) begin
                    issue = 1'b1;
                    // On a tie, whoever was not granted last goes first.
                    if (a_cmd_en && b_cmd_en) begin
                        winner = (last_grant == REQ_B) ? REQ_A : REQ_B;
                    end else begin
                        winner = a_cmd_en ? REQ_A : REQ_B;
                    end
                    owner_next      = winner;
                    last_grant_next = winner;
                    if ((winner == REQ_B) ? b_cmd : a_cmd) begin
                        // Beat 0 goes out with the command itself.
                        state_next    = WRITE_BEATS;
                        beat_cnt_next = BEAT_CNT_BITWIDTH'(1);
                    end else begin
                        state_next    = READ_WAIT;
                        beat_cnt_next = '0;
                    end
                end
            end
            WRITE_BEATS: begin
                beat_cnt_next = beat_cnt + BEAT_CNT_BITWIDTH'(1);
                if (beat_cnt == LAST_BEAT) begin
                    state_next    = IDLE;
                    beat_cnt_next = '0;
                end
            end
            READ_WAIT: begin
                if (br_rd_data_valid) begin
                    beat_cnt_next = beat_cnt + BEAT_CNT_BITWIDTH'(1);
                    if (beat_cnt == LAST_BEAT) begin
                        state_next    = IDLE;
                        beat_cnt_next = '0;
                    end
                end
            end
            default: begin
                state_next    = IDLE;
                beat_cnt_next = '0;
            end
        endcase
    end

    // In IDLE the source is this cycle's winner; during a write burst it is the owner.
    assign src         = (state == IDLE) ? winner : owner;
    assign src_cmd     = (src == REQ_B) ? b_cmd : a_cmd;
    assign src_addr    = (src == REQ_B) ? b_addr : a_addr;
    assign src_wr_data = (src == REQ_B) ? b_wr_data : a_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            br_cmd_en  <= 1'b0;
            br_cmd     <= 1'b0;
            br_addr    <= '0;
            br_wr_data <= '0;
            a_cmd_ack  <= 1'b0;
            b_cmd_ack  <= 1'b0;
        end else begin
            br_cmd_en <= issue;
            a_cmd_ack <= issue && (winner == REQ_A);
            b_cmd_ack <= issue && (winner == REQ_B);
            if (issue) begin
                br_cmd     <= src_cmd;
                br_addr    <= src_addr;
                br_wr_data <= src_wr_data;
            end else if (state == WRITE_BEATS) begin
                br_wr_data <= src_wr_data;
            end
        end
    end

    // Read beats are forwarded with no added latency, only to the owner, and
    // never while reset is applied.
    assign a_rd_data       = br_rd_data;
    assign b_rd_data       = br_rd_data;
    assign a_rd_data_valid = !rst && (state == READ_WAIT) && (owner == REQ_A) && br_rd_data_valid;
    assign b_rd_data_valid = !rst && (state == READ_WAIT) && (owner == REQ_B) && br_rd_data_valid;
    assign br_data_mask    = 8'h00;

endmodule
